// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the requesters and the register-file write arbiter.
// Master side: the writeback sources (valid/addr/data out, ready in).
// Slave side: the arbiter (ready and the registered regfile write port out).
interface regfile_write_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
);
   localparam int GID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [ADDR_W-1:0]         A3;
   logic [DATA_W-1:0]         WD3;
   logic                      WE3;
   logic [GID_W-1:0]          grant_id;
   logic                      init_done;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, A3, WD3, WE3, grant_id, init_done
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, A3, WD3, WE3, grant_id, init_done
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose: owns the regfile write port; clears all registers after reset, then round-robins NUM_REQ writers.
// Latency: 1 cycle from valid&ready to the registered WE3/A3/WD3 pulse; one write per cycle.
// Backpressure: req_ready is a combinational one-hot grant, held low during the init sweep.
// Option: RWARB_X0_GUARD_EN drops run-time writes to address 0 (handshake still completes).
module regfile_write_arbiter #(
   parameter int                NUM_REQ  = 3,
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 5,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input logic                    clk,
   input logic                    rst_n,
   regfile_write_arbiter_if.slave bus
);
   localparam int GID_W = $clog2(NUM_REQ);

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Registered state and outputs
   state_t              state_q;
   logic [ADDR_W:0]     cnt_q;      // extra MSB marks "all registers written"
   logic [GID_W-1:0]    ptr_q;
   logic [ADDR_W-1:0]   a3_q;
   logic [DATA_W-1:0]   wd3_q;
   logic                we3_q;
   logic [GID_W-1:0]    gid_q;
   logic                done_q;

   // Combinational grant
   logic [NUM_REQ-1:0]  gnt_oh;
   logic [GID_W-1:0]    gnt_idx;
   logic                gnt_vld;
   logic [GID_W-1:0]    cand;
   int                  pos;
   logic [GID_W-1:0]    ptr_d;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic                we3_run_d;

   logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
   logic [DATA_W-1:0]   data_arr [NUM_REQ];

   // Unpack the flat requester buses into per-requester lanes
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
         data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
      end
   end

   // Round-robin pick: first valid requester at or after ptr, wrapping
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand    = '0;
      pos     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = int'(ptr_q) + k;
         if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
         end
         cand = GID_W'(pos);
         if (!gnt_vld && bus.req_valid[cand]) begin
            gnt_vld      = 1'b1;
            gnt_idx      = cand;
            gnt_oh[cand] = 1'b1;
         end
      end
      // Nobody is served while the sweep owns the write port
      if (state_q != S_RUN) begin
         gnt_vld = 1'b0;
         gnt_oh  = '0;
      end
   end

   // Winner's payload and the pointer value after its transfer
   always_comb begin
      sel_addr = addr_arr[gnt_idx];
      sel_data = data_arr[gnt_idx];
      if (gnt_idx == GID_W'(NUM_REQ - 1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = gnt_idx + GID_W'(1);
      end
`ifdef RWARB_X0_GUARD_EN
      // x0 is hard-wired to INIT_VAL: accept the transfer but suppress the write
      we3_run_d = (sel_addr != '0);
`else
      we3_run_d = 1'b1;
`endif
   end

   // Main FSM: init sweep over every address, then one granted write per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         ptr_q   <= '0;
         a3_q    <= '0;
         wd3_q   <= '0;
         we3_q   <= 1'b0;
         gid_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               if (!cnt_q[ADDR_W]) begin
                  we3_q <= 1'b1;
                  a3_q  <= cnt_q[ADDR_W-1:0];
                  wd3_q <= INIT_VAL;
                  cnt_q <= cnt_q + (ADDR_W+1)'(1);
               end else begin
                  // Last sweep write is already on the port; hand over to requesters
                  we3_q   <= 1'b0;
                  state_q <= S_RUN;
                  done_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (gnt_vld) begin
                  we3_q <= we3_run_d;
                  a3_q  <= sel_addr;
                  wd3_q <= sel_data;
                  gid_q <= gnt_idx;
                  ptr_q <= ptr_d;
               end else begin
                  // Idle slot: drop the enable, keep address/data/id stable
                  we3_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_INIT;
            end
         endcase
      end
   end

   assign bus.req_ready = gnt_oh;
   assign bus.A3        = a3_q;
   assign bus.WD3       = wd3_q;
   assign bus.WE3       = we3_q;
   assign bus.grant_id  = gid_q;
   assign bus.init_done = done_q;

   // Grant is at most one-hot and never raised before the sweep completes
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert ($onehot0(gnt_oh));
         assert (done_q || gnt_oh == '0);
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: init sweep, round-robin order,
// same-address ordering, address-0 handling, reset during RUN, single requester.
module tb_regfile_write_arbiter;
   localparam int NUM_REQ = 3;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   regfile_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_write_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .INIT_VAL('0)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.req_addr[i*ADDR_W +: ADDR_W] = a;
      bus.req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic check_sweep(input string tag);
      for (int i = 0; i < 32; i++) begin
         step();
         check({tag, "_we"},    32'(bus.WE3), 32'd1);
         check({tag, "_a3"},    32'(bus.A3), 32'(i));
         check({tag, "_wd"},    bus.WD3, 32'd0);
         check({tag, "_rdy"},   32'(bus.req_ready), 32'd0);
         check({tag, "_done"},  32'(bus.init_done), 32'd0);
      end
   endtask

   initial begin
      int g;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;

      // 1: reset values, then the 32-cycle sweep
      repeat (2) step();
      check("rst_we",   32'(bus.WE3), 32'd0);
      check("rst_a3",   32'(bus.A3), 32'd0);
      check("rst_wd",   bus.WD3, 32'd0);
      check("rst_gid",  32'(bus.grant_id), 32'd0);
      check("rst_done", 32'(bus.init_done), 32'd0);
      check("rst_rdy",  32'(bus.req_ready), 32'd0);
      rst_n = 1'b1;
      check_sweep("sweep");
      step();
      check("post_done", 32'(bus.init_done), 32'd1);
      check("post_we",   32'(bus.WE3), 32'd0);
      check("post_rdy",  32'(bus.req_ready), 32'd0);

      // 2: all three requesters valid continuously
      set_req(0, 5'd1, 32'hA);
      set_req(1, 5'd2, 32'hB);
      set_req(2, 5'd3, 32'hC);
      bus.req_valid = 3'b111;
      for (int j = 0; j < 6; j++) begin
         g = j % 3;
         #1;
         check("rr_rdy", 32'(bus.req_ready), 32'(1 << g));
         step();
         check("rr_we",  32'(bus.WE3), 32'd1);
         check("rr_a3",  32'(bus.A3), 32'(g + 1));
         check("rr_wd",  bus.WD3, 32'(32'hA + g));
         check("rr_gid", 32'(bus.grant_id), 32'(g));
      end
      bus.req_valid = '0;
      step();
      check("rr_idle_we", 32'(bus.WE3), 32'd0);
      check("rr_idle_a3", 32'(bus.A3), 32'd3);
      check("rr_idle_wd", bus.WD3, 32'hC);

      // 3: move ptr to 2 via a lone req1 grant, then req1/req2 both hit addr 5
      set_req(1, 5'd7, 32'h77);
      bus.req_valid = 3'b010;
      #1;
      check("pre_rdy", 32'(bus.req_ready), 32'b010);
      step();
      set_req(1, 5'd5, 32'h11);
      set_req(2, 5'd5, 32'h22);
      bus.req_valid = 3'b110;
      #1;
      check("same_rdy0", 32'(bus.req_ready), 32'b100);
      step();
      check("same_a3_0",  32'(bus.A3), 32'd5);
      check("same_wd_0",  bus.WD3, 32'h22);
      check("same_gid_0", 32'(bus.grant_id), 32'd2);
      bus.req_valid = 3'b010;
      #1;
      check("same_rdy1", 32'(bus.req_ready), 32'b010);
      step();
      check("same_we_1",  32'(bus.WE3), 32'd1);
      check("same_a3_1",  32'(bus.A3), 32'd5);
      check("same_wd_1",  bus.WD3, 32'h11);
      check("same_gid_1", 32'(bus.grant_id), 32'd1);
      bus.req_valid = '0;
      step();
      check("same_idle_we", 32'(bus.WE3), 32'd0);

      // 4: req0 writes address 0 (ptr is 2, wraps to 0)
      set_req(0, 5'd0, 32'hFF);
      bus.req_valid = 3'b001;
      #1;
      check("x0_rdy", 32'(bus.req_ready), 32'b001);
      step();
`ifdef RWARB_X0_GUARD_EN
      check("x0_we", 32'(bus.WE3), 32'd0);
`else
      check("x0_we", 32'(bus.WE3), 32'd1);
      check("x0_a3", 32'(bus.A3), 32'd0);
      check("x0_wd", bus.WD3, 32'hFF);
`endif
      bus.req_valid = '0;

      // 6: only req2 valid for 4 cycles (ptr is 1)
      for (int k = 0; k < 4; k++) begin
         set_req(2, 5'd9, 32'(32'h90 + k));
         bus.req_valid = 3'b100;
         #1;
         check("solo_rdy", 32'(bus.req_ready), 32'b100);
         step();
         check("solo_we",  32'(bus.WE3), 32'd1);
         check("solo_a3",  32'(bus.A3), 32'd9);
         check("solo_wd",  bus.WD3, 32'h93 - 32'(3 - k));
         check("solo_gid", 32'(bus.grant_id), 32'd2);
      end
      bus.req_valid = '0;
      step();
      check("solo_idle_we", 32'(bus.WE3), 32'd0);
      check("solo_idle_a3", 32'(bus.A3), 32'd9);
      check("solo_idle_wd", bus.WD3, 32'h93);
      step();
      check("solo_hold_a3", 32'(bus.A3), 32'd9);
      check("solo_hold_wd", bus.WD3, 32'h93);

      // 5: reset pulse in RUN with req0 pending
      set_req(0, 5'd4, 32'h44);
      bus.req_valid = 3'b001;
      #1;
      check("rr5_rdy", 32'(bus.req_ready), 32'b001);
      rst_n = 1'b0;
      #1;
      check("mid_rst_we",   32'(bus.WE3), 32'd0);
      check("mid_rst_a3",   32'(bus.A3), 32'd0);
      check("mid_rst_wd",   bus.WD3, 32'd0);
      check("mid_rst_gid",  32'(bus.grant_id), 32'd0);
      check("mid_rst_done", 32'(bus.init_done), 32'd0);
      check("mid_rst_rdy",  32'(bus.req_ready), 32'd0);
      #1;
      rst_n = 1'b1;
      check_sweep("resweep");
      step();
      check("re_done", 32'(bus.init_done), 32'd1);
      check("re_we",   32'(bus.WE3), 32'd0);
      check("re_rdy",  32'(bus.req_ready), 32'b001);
      step();
      check("re_gnt_we",  32'(bus.WE3), 32'd1);
      check("re_gnt_a3",  32'(bus.A3), 32'd4);
      check("re_gnt_wd",  bus.WD3, 32'h44);
      check("re_gnt_gid", 32'(bus.grant_id), 32'd0);
      bus.req_valid = '0;
      step();
      check("end_we", 32'(bus.WE3), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
